// File: rtl/instr_fetch.sv
// Instruction fetch unit with a single outstanding memory request.
//
// Fetches one word at a time from instruction memory and presents it downstream
// until consumed. Control-flow redirects take priority over stalls and sequential
// advance; responses belonging to a request issued before a redirect are drained
// and dropped.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   o_imem_req/o_imem_addr   memory request (handshake with i_imem_gnt)
//   i_imem_rvalid/rdata      memory response
//   i_stall                  downstream cannot consume the held instruction
//   i_redirect/_pc           control-flow change and its target
//   o_valid/o_instr/o_pc     held fetched instruction and its address
//   o_pcplus4                o_pc + 4 (mod 2^32)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcplus4
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold,
    StDrain
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;

  logic [31:0] target;
  logic        unused_redirect_lsb;

  // Targets are forced word-aligned; the low bits carry no meaning here.
  assign target              = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;

    case (state_q)
      StFetch: begin
        if (i_redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          // A request granted this cycle is already in flight and must be drained.
          state_d = i_imem_gnt ? StDrain : StFetch;
        end else if (i_imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (i_redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = i_imem_rvalid ? StFetch : StDrain;
        end else if (i_imem_rvalid) begin
          instr_d = i_imem_rdata;
          opc_d   = pc_q;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (i_redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (!i_stall) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (i_redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end
        // The stale response retires the outstanding request even if a new
        // redirect lands in the same cycle; otherwise we would wait forever.
        if (i_imem_rvalid) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= Nop;
      opc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  assign o_imem_req  = (state_q == StFetch) && !i_rst;
  assign o_imem_addr = pc_q;
  assign o_valid     = valid_q;
  assign o_instr     = instr_q;
  assign o_pc        = opc_q;
  assign o_pcplus4   = opc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized stimulus, every cycle
// compared against a transaction-level model (outstanding/discard/holding flags).
module tb_instr_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        i_clk;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pcplus4;

  instr_fetch #(.RESET_PC(ResetPc)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_pcplus4     (o_pcplus4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: request outstanding, its response to be dropped, and the
  // held instruction downstream.
  logic        m_init = 1'b0;
  logic        m_out, m_disc, m_valid;
  logic [31:0] m_pc, m_instr, m_opc;

  task automatic compare();
    if (i_rst) check("req_in_rst", {31'b0, o_imem_req}, 32'd0);
    if (m_init) begin
      if (!i_rst) check("req", {31'b0, o_imem_req}, {31'b0, !m_out && !m_valid});
      check("addr", o_imem_addr, m_pc);
      check("valid", {31'b0, o_valid}, {31'b0, m_valid});
      check("instr", o_instr, m_instr);
      check("pc", o_pc, m_opc);
      check("pcplus4", o_pcplus4, m_opc + 32'd4);
    end
  endtask

  task automatic model_step();
    logic hs, resp;
    if (i_rst) begin
      m_init  = 1'b1;
      m_out   = 1'b0;
      m_disc  = 1'b0;
      m_valid = 1'b0;
      m_pc    = ResetPc;
      m_instr = 32'h0000_0013;
      m_opc   = ResetPc;
    end else if (m_init) begin
      hs   = !m_out && !m_valid && i_imem_gnt;
      resp = m_out && i_imem_rvalid;
      if (i_redirect) begin
        m_pc    = {i_redirect_pc[31:2], 2'b00};
        m_valid = 1'b0;
        if (hs) begin
          m_out  = 1'b1;
          m_disc = 1'b1;
        end else if (resp) begin
          m_out  = 1'b0;
          m_disc = 1'b0;
        end else if (m_out) begin
          m_disc = 1'b1;
        end
      end else if (hs) begin
        m_out  = 1'b1;
        m_disc = 1'b0;
      end else if (resp) begin
        m_out = 1'b0;
        if (!m_disc) begin
          m_valid = 1'b1;
          m_instr = i_imem_rdata;
          m_opc   = m_pc;
        end
        m_disc = 1'b0;
      end else if (m_valid && !i_stall) begin
        m_valid = 1'b0;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic stall,
                       input logic redir, input logic [31:0] rpc);
    i_rst         = rst;
    i_imem_gnt    = gnt;
    i_imem_rvalid = rv;
    i_imem_rdata  = rdata;
    i_stall       = stall;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    #1;
    compare();
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge i_clk);
    tick();
    // Reset overrides redirect, stall and responses.
    drive(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0400);
    tick();

    // Basic fetch, 3-cycle loop.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("d_req0", {31'b0, o_imem_req}, 32'd1);
    check("d_addr0", o_imem_addr, 32'h0);
    check("d_nop", o_instr, 32'h0000_0013);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("d_valid", {31'b0, o_valid}, 32'd1);
    check("d_instr", o_instr, 32'h0050_0093);
    check("d_pc", o_pc, 32'h0);
    check("d_pc4", o_pcplus4, 32'h4);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("d_addr4", o_imem_addr, 32'h4);
    tick();

    // Stall holds the instruction.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h00A0_0113, 1'b1, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check("stall_valid", {31'b0, o_valid}, 32'd1);
      check("stall_instr", o_instr, 32'h00A0_0113);
      check("stall_pc", o_pc, 32'h4);
      check("stall_req", {31'b0, o_imem_req}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("stall_next", o_imem_addr, 32'h8);
    tick();

    // Redirect in WAIT, stale response dropped.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("drain_req", {31'b0, o_imem_req}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    check("drain_valid", {31'b0, o_valid}, 32'd0);
    tick();

    // Grant withheld, then redirect while waiting for it.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("nogt_req", {31'b0, o_imem_req}, 32'd1);
      check("nogt_addr", o_imem_addr, 32'h100);
      check("nogt_valid", {31'b0, o_valid}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0202);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("redir_addr", o_imem_addr, 32'h200);
    tick();

    // Wraparound at the top of the address space.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("wrap_pc", o_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", o_pcplus4, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("wrap_next", o_imem_addr, 32'h0);
    tick();

    // Reset during WAIT; late response after release ignored.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_addr", o_imem_addr, ResetPc);
    check("rst_req", {31'b0, o_imem_req}, 32'd1);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(1) == 1),
            ($urandom_range(9) < 4), $urandom, ($urandom_range(9) < 4),
            ($urandom_range(9) == 0), $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 o_imem_req  output  1  instruction-memory request valid.
REQ-005 o_imem_addr  output  32  request byte address, word-aligned.
REQ-006 i_imem_gnt  input  1  memory accepts request this cycle (req && gnt = handshake).
REQ-007 i_imem_rvalid  input  1  read data valid.
REQ-008 i_imem_rdata  input  32  instruction word.
REQ-009 i_stall  input  1  downstream cannot consume held instruction.
REQ-010 i_redirect  input  1  control-flow change (taken branch/jump).
REQ-011 i_redirect_pc  input  32  redirect target.
REQ-012 o_valid  output  1  o_instr/o_pc hold a valid fetched instruction.
REQ-013 o_instr  output  32  fetched instruction; bits [31:7] feed the immediate extender.
REQ-014 o_pc  output  32  address of o_instr.
REQ-015 o_pcplus4  output  32  o_pc + 4, modulo 2^32.

Function
REQ-016 FSM states SHALL be FETCH, WAIT, HOLD, DRAIN; at most one memory request outstanding.
REQ-017 o_imem_req SHALL be 1 only in FETCH; o_imem_addr SHALL equal internal fetch pc in every state.
REQ-018 FETCH: i_imem_gnt=1 -> WAIT; else stay FETCH, address held stable.
REQ-019 WAIT: i_imem_rvalid=1 -> load o_instr<=rdata, o_pc<=fetch pc, o_valid<=1, -> HOLD; else stay.
REQ-020 HOLD: i_stall=0 -> o_valid<=0, fetch pc<=fetch pc+4 (wraps 32'hFFFF_FFFC->0), -> FETCH; i_stall=1 -> outputs held unchanged.
REQ-021 Response latency: o_valid rises the edge after the rvalid cycle; minimum fetch-to-fetch interval 3 cycles (FETCH, WAIT, HOLD).
REQ-022 i_redirect SHALL take priority over i_stall and over pc+4 advance in every state.
REQ-023 On redirect: fetch pc<={i_redirect_pc[31:2],2'b00}; o_valid<=0 same edge; low two target bits ignored.
REQ-024 Redirect in FETCH without gnt or in HOLD -> FETCH; next request uses new target.
REQ-025 Redirect in FETCH with gnt same cycle, or in WAIT without rvalid -> DRAIN (old request in flight).
REQ-026 Redirect in WAIT with rvalid same cycle: response discarded, o_valid stays 0, -> FETCH.
REQ-027 DRAIN: o_imem_req=0; rvalid=1 -> data discarded, -> FETCH; a further redirect in DRAIN updates fetch pc and stays DRAIN.
REQ-028 i_imem_rvalid in FETCH or HOLD (no request outstanding) SHALL be ignored.
REQ-029 o_pcplus4 SHALL be combinational from o_pc; o_instr never changes while o_valid=1 and i_stall=1 unless redirect/reset.

Reset
REQ-030 i_rst=1 at a rising edge: state<=FETCH, fetch pc<=RESET_PC, o_valid<=0, o_instr<=32'h0000_0013 (NOP), o_pc<=RESET_PC.
REQ-031 While i_rst=1, o_imem_req SHALL be 0; reset overrides redirect, stall and any in-flight response.
REQ-032 Reset mid-transaction: a response arriving after reset release, before the first new grant, SHALL be discarded (FSM starts in FETCH, ignores rvalid per REQ-028).

Verification
REQ-033 Reset release, gnt=1 always, rvalid one cycle after grant, rdata=32'h0050_0093, i_stall=0 -> req addr 0x0; o_valid=1 with o_instr=0x00500093, o_pc=0, o_pcplus4=4; next req addr 0x4.
REQ-034 Hold i_stall=1 for 5 cycles in HOLD -> o_valid, o_instr, o_pc constant, o_imem_req=0; release -> next request at o_pc+4.
REQ-035 Redirect to 32'h0000_0103 while in WAIT, old rvalid arrives 2 cycles later with 0xDEADBEEF -> data dropped, o_valid never 1 for it; next req addr 0x100.
REQ-036 gnt withheld 4 cycles -> o_imem_req stays 1, o_imem_addr stable; redirect during wait -> addr switches to target next cycle.
REQ-037 Fetch pc at 32'hFFFF_FFFC consumed -> next req addr 0x0; o_pcplus4 of that instruction = 0x0.
REQ-038 Assert i_rst during WAIT with rvalid one cycle after release -> response ignored, o_valid=0, first request at RESET_PC.
